// File: rtl/operation_sequencer.sv
// ============================================================================
// Module   : operation_sequencer
// Function : Runs a host-loaded program into operation_machine, one timed
//            instruction at a time, and captures the machine output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operation_sequencer #(
  parameter int N     = 32,
  parameter int Q     = 16,
  parameter int stack = 5,
  parameter int DEPTH = 16,
  parameter int HOLD  = 2,
  localparam int IW   = $clog2(stack) + 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = 3 + 3*IW + N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [PW-1:0] prog_data,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic [AW-1:0] pc,
  output logic          mo_rst,
  output logic [2:0]    mo_operand,
  output logic [IW-1:0] mo_index1,
  output logic [IW-1:0] mo_index2,
  output logic [IW-1:0] mo_index3,
  output logic [N-1:0]  mo_value,
  input  logic [N-1:0]  mo_out
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [AW:0]   c_depth     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_len_one   = (AW+1)'(1);
  localparam logic [AW-1:0] c_pc_one    = AW'(1);
  localparam logic [CW-1:0] c_cnt_one   = CW'(1);
  localparam logic [CW-1:0] c_hold_last = CW'(HOLD - 1);

  // Operands latch in the first held cycle and write back in the second.
  generate
    if (HOLD < 2 || Q > N) begin : g_param_check
      $error("operation_sequencer: HOLD must be >= 2 and Q must not exceed N");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ISSUE  = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW:0]   r_len, w_len_nxt, w_len_clip;
  logic [N-1:0]  r_result;
  logic [PW-1:0] r_mem [DEPTH];
  logic [PW-1:0] w_inst;
  logic          w_issue;

  // Program memory survives reset so a run can be repeated after an abort.
  always_ff @(posedge clk) begin
    if (prog_we && r_state == S_IDLE) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      if (r_state == S_FINISH) begin
        r_result <= mo_out;
      end
    end
  end

  assign w_len_clip = (len > c_depth) ? c_depth : len;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_len_nxt   = w_len_clip;
          w_state_nxt = (w_len_clip == '0) ? S_FINISH : S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_pc_nxt    = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_cnt == c_hold_last) begin
          w_cnt_nxt = '0;
          // pc stays on the last instruction so it reads back the final index
          if ({1'b0, r_pc} == r_len - c_len_one) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_pc_nxt = r_pc + c_pc_one;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      S_DRAIN:  w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_inst  = r_mem[r_pc];
  assign w_issue = (r_state == S_ISSUE);

  // busy covers the accepting IDLE cycle as well as the whole run.
  assign busy       = (r_state != S_IDLE) || (start && !rst);
  assign done       = (r_state == S_FINISH);
  assign mo_rst     = (r_state == S_CLEAR);
  assign result     = r_result;
  assign pc         = r_pc;
  assign mo_operand = w_issue ? w_inst[PW-1 -: 3]        : 3'b000;
  assign mo_index1  = w_issue ? w_inst[N+3*IW-1 -: IW]   : '0;
  assign mo_index2  = w_issue ? w_inst[N+2*IW-1 -: IW]   : '0;
  assign mo_index3  = w_issue ? w_inst[N+IW-1 -: IW]     : '0;
  assign mo_value   = w_issue ? w_inst[N-1:0]            : '0;

endmodule

`default_nettype wire

// File: tb/tb_operation_sequencer.sv
// ============================================================================
// Module   : tb_operation_sequencer
// Function : Directed bench for operation_sequencer with a small machine model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operation_sequencer;

  localparam int N     = 32;
  localparam int Q     = 16;
  localparam int STACK = 5;
  localparam int DEPTH = 16;
  localparam int HOLD  = 2;
  localparam int IW    = $clog2(STACK) + 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = 3 + 3*IW + N;

  logic          clk, rst, prog_we, start, busy, done, mo_rst;
  logic [AW-1:0] prog_addr, pc;
  logic [PW-1:0] prog_data;
  logic [AW:0]   len;
  logic [N-1:0]  result, mo_value, mo_out;
  logic [2:0]    mo_operand;
  logic [IW-1:0] mo_index1, mo_index2, mo_index3;

  int n_cmp = 0;
  int n_bad = 0;

  operation_sequencer #(.N(N), .Q(Q), .stack(STACK), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .len(len), .busy(busy), .done(done), .result(result), .pc(pc),
    .mo_rst(mo_rst), .mo_operand(mo_operand), .mo_index1(mo_index1), .mo_index2(mo_index2),
    .mo_index3(mo_index3), .mo_value(mo_value), .mo_out(mo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Machine model: 001 loads reg[i1], 010 loads reg[i2], 011 latches then adds into reg[i3].
  logic [N-1:0] m_regs [32];
  logic [N-1:0] m_a, m_b;
  logic         m_phase;
  always @(posedge clk) begin
    if (mo_rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      mo_out  <= '0;
      m_phase <= 1'b0;
    end else begin
      case (mo_operand)
        3'b001: begin m_regs[mo_index1] <= mo_value; m_phase <= 1'b0; end
        3'b010: begin m_regs[mo_index2] <= mo_value; m_phase <= 1'b0; end
        3'b011: begin
          if (!m_phase) begin
            m_a <= m_regs[mo_index1];
            m_b <= m_regs[mo_index2];
            m_phase <= 1'b1;
          end else begin
            m_regs[mo_index3] <= m_a + m_b;
            mo_out  <= m_a + m_b;
            m_phase <= 1'b0;
          end
        end
        default: m_phase <= 1'b0;
      endcase
    end
  end

  function automatic logic [PW-1:0] mk(input logic [2:0] op, input logic [IW-1:0] a,
                                       input logic [IW-1:0] b, input logic [IW-1:0] c,
                                       input logic [N-1:0] v);
    return {op, a, b, c, v};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      prog_we   = 1'b1;
      prog_addr = AW'(i);
      case (i)
        0:       prog_data = mk(3'b001, 5'd1, 5'd0, 5'd0, 32'h0002_0000);
        1:       prog_data = mk(3'b010, 5'd0, 5'd2, 5'd0, 32'h0003_0000);
        2:       prog_data = mk(3'b011, 5'd1, 5'd2, 5'd1, 32'h0000_0000);
        default: prog_data = mk(3'b001, IW'(i + 7), 5'd0, 5'd0, N'(i));
      endcase
      @(negedge clk);
    end
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (mo_rst !== 1'b0) begin n_bad++; $display("FAIL reset_mo_rst: got %b want 0", mo_rst); end
    n_cmp++; if (pc !== '0) begin n_bad++; $display("FAIL reset_pc: got %0d want 0", pc); end
    n_cmp++; if (mo_operand !== 3'b000) begin n_bad++; $display("FAIL reset_operand: got %b want 000", mo_operand); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_program();
    logic [2:0] e;
    len = 4'd3; start = 1'b1; #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL prog_busy_start: got %b want 1", busy); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      e = (k >= 2 && k <= 7) ? 3'(k / 2) : 3'b000;
      n_cmp++; if (mo_operand !== e) begin n_bad++; $display("FAIL prog_operand k=%0d: got %b want %b", k, mo_operand, e); end
      n_cmp++; if (mo_rst !== (k == 1)) begin n_bad++; $display("FAIL prog_mo_rst k=%0d: got %b want %b", k, mo_rst, k == 1); end
      n_cmp++; if (done !== (k == 9)) begin n_bad++; $display("FAIL prog_done k=%0d: got %b want %b", k, done, k == 9); end
      if (k == 2) begin
        n_cmp++; if (mo_index1 !== 5'd1 || mo_value !== 32'h0002_0000) begin n_bad++;
          $display("FAIL prog_fields0: got i1=%0d v=%h want i1=1 v=00020000", mo_index1, mo_value); end
      end
      if (k == 6) begin
        n_cmp++; if ({mo_index1, mo_index2, mo_index3} !== {5'd1, 5'd2, 5'd1}) begin n_bad++;
          $display("FAIL prog_fields2: got %0d/%0d/%0d want 1/2/1", mo_index1, mo_index2, mo_index3); end
      end
      if (k == 9) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL prog_busy_finish: got %b want 1", busy); end
      end
      if (k == 10) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL prog_busy_idle: got %b want 0", busy); end
        n_cmp++; if (result !== 32'h0005_0000) begin n_bad++; $display("FAIL prog_result: got %h want 00050000", result); end
      end
    end
  endtask

  task automatic test_len_zero();
    len = '0; start = 1'b1; #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy_start: got %b want 1", busy); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (mo_operand !== 3'b000 || mo_rst !== 1'b0) begin n_bad++;
        $display("FAIL zero_idle_outputs k=%0d: got op=%b mo_rst=%b want 000/0", k, mo_operand, mo_rst); end
      n_cmp++; if (done !== (k == 1) || busy !== (k == 1)) begin n_bad++;
        $display("FAIL zero_done_busy k=%0d: got done=%b busy=%b want %b", k, done, busy, k == 1); end
    end
    n_cmp++; if (result !== 32'h0005_0000) begin n_bad++; $display("FAIL zero_result: got %h want 00050000", result); end
  endtask

  task automatic test_len_clip();
    int n_issue = 0, k_done = 0, n_done = 0;
    len = 5'd20; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mo_operand !== 3'b000) n_issue++;
      if (done === 1'b1) begin n_done++; k_done = k; end
      if (k == 34) begin
        n_cmp++; if (pc !== AW'(15)) begin n_bad++; $display("FAIL clip_pc: got %0d want 15", pc); end
      end
    end
    n_cmp++; if (n_issue != 32) begin n_bad++; $display("FAIL clip_issue_cycles: got %0d want 32", n_issue); end
    n_cmp++; if (k_done != 35 || n_done != 1) begin n_bad++;
      $display("FAIL clip_done: got cycle %0d count %0d want cycle 35 count 1", k_done, n_done); end
  endtask

  task automatic test_busy_ignore();
    len = 4'd3; start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = 1'b0; prog_we = 1'b0;
      n_cmp++; if (done !== (k == 9)) begin n_bad++; $display("FAIL busy_done k=%0d: got %b want %b", k, done, k == 9); end
      if (k == 3) begin
        prog_we = 1'b1; prog_addr = '0; prog_data = mk(3'b111, 5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF);
        start = 1'b1; len = 5'd1;
      end
    end
  endtask

  task automatic test_readback();
    len = 4'd3; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 2) begin
        n_cmp++; if (mo_operand !== 3'b001 || mo_value !== 32'h0002_0000) begin n_bad++;
          $display("FAIL readback_entry0: got op=%b v=%h want 001/00020000", mo_operand, mo_value); end
      end
      if (k == 10) begin
        n_cmp++; if (result !== 32'h0005_0000) begin n_bad++; $display("FAIL readback_result: got %h want 00050000", result); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    len = 4'd3; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin @(negedge clk); start = 1'b0; end
    n_cmp++; if (mo_operand !== 3'b010) begin n_bad++; $display("FAIL abort_pre_op: got %b want 010", mo_operand); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, done, mo_rst} !== 3'b000) begin n_bad++;
      $display("FAIL abort_flags: got busy/done/mo_rst=%b want 000", {busy, done, mo_rst}); end
    n_cmp++; if (pc !== '0 || mo_operand !== 3'b000) begin n_bad++;
      $display("FAIL abort_pc_op: got pc=%0d op=%b want 0/000", pc, mo_operand); end
    n_cmp++; if ({mo_index1, mo_index2, mo_index3} !== '0 || mo_value !== '0) begin n_bad++;
      $display("FAIL abort_fields: got idx=%h v=%h want 0", {mo_index1, mo_index2, mo_index3}, mo_value); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL abort_result: got %h want 0", result); end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (done === 1'b1) n_done++; end
    n_cmp++; if (n_done != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", n_done); end
    len = 4'd3; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 2) begin
        n_cmp++; if (pc !== '0 || mo_operand !== 3'b001) begin n_bad++;
          $display("FAIL restart_first: got pc=%0d op=%b want 0/001", pc, mo_operand); end
      end
      if (k == 9) begin
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL restart_done: got %b want 1", done); end
      end
      if (k == 10) begin
        n_cmp++; if (result !== 32'h0005_0000) begin n_bad++; $display("FAIL restart_result: got %h want 00050000", result); end
      end
    end
  endtask

  task automatic test_back_to_back();
    len = 4'd3; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 9) begin
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done: got %b want 1", done); end
      end
    end
    // Same-cycle write and start: the new entry 0 must be the one issued.
    prog_we = 1'b1; prog_addr = '0; prog_data = mk(3'b001, 5'd1, 5'd0, 5'd0, 32'h0004_0000);
    len = 4'd3; start = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      start = 1'b0; prog_we = 1'b0;
      if (j == 2) begin
        n_cmp++; if (mo_value !== 32'h0004_0000) begin n_bad++; $display("FAIL b2b_new_entry: got %h want 00040000", mo_value); end
      end
      if (j <= 9) begin
        n_cmp++; if (result !== 32'h0005_0000) begin n_bad++; $display("FAIL b2b_hold j=%0d: got %h want 00050000", j, result); end
      end
      n_cmp++; if (done !== (j == 9)) begin n_bad++; $display("FAIL b2b_done j=%0d: got %b want %b", j, done, j == 9); end
      if (j == 10) begin
        n_cmp++; if (result !== 32'h0007_0000) begin n_bad++; $display("FAIL b2b_result: got %h want 00070000", result); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; len = '0;
    @(negedge clk);
    test_reset();
    load_prog();
    test_program();
    test_len_zero();
    test_len_clip();
    test_busy_ignore();
    test_readback();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/operation_sequencer.md
Name: operation_sequencer

Overview:
Program-driven controller for `operation_machine`. It holds a small instruction memory, and on `start` it resets the machine, then issues each instruction (operand, three indices, load value) for a fixed number of cycles. After the last instruction it captures the machine's `out` as the result and pulses `done`. It is the block that turns a host-loaded equation program into a timed operand stream for the fixed-point datapath.

Parameters:
- N, 32: fixed-point word width; must match the driven machine.
- Q, 16: fractional bits; carried for consistency only, no arithmetic is done here.
- stack, 5: machine stack depth. Index width IW = $clog2(stack)+2.
- DEPTH, 16: number of instruction memory entries. AW = $clog2(DEPTH).
- HOLD, 2: cycles each instruction is held on the machine inputs. Must be at least 2, because arithmetic ops latch operands in the first cycle and write back in the second.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- prog_we  in  1  instruction memory write enable
- prog_addr  in  AW  write address
- prog_data  in  3+3*IW+N  packed instruction {operand, index1, index2, index3, value}, operand in the MSBs
- start  in  1  begin executing the program
- len  in  AW+1  number of instructions to run, sampled on accepted start
- busy  out  1  high from accepted start until done, inclusive
- done  out  1  one-cycle completion pulse
- result  out  N  captured machine output, held until the next done
- pc  out  AW  index of the instruction currently issued
- mo_rst  out  1  reset to the machine
- mo_operand  out  3  operand to the machine
- mo_index1  out  IW  index1 to the machine
- mo_index2  out  IW  index2 to the machine
- mo_index3  out  IW  index3 to the machine
- mo_value  out  N  load value to the machine
- mo_out  in  N  machine output

Behaviour:
- Reset: state IDLE; `busy`, `done`, `mo_rst` = 0; `result` = 0; `pc` = 0; `mo_operand` = 000; `mo_index*` and `mo_value` = 0.
  - Instruction memory is not cleared by reset; its contents are retained.
  - Reset asserted mid-run aborts the program: next cycle is IDLE with no done pulse.
- Memory write: `prog_we` is accepted only in IDLE and takes effect at the clock edge. Writes while busy are dropped.
- FSM states: IDLE -> CLEAR -> ISSUE -> DRAIN -> FINISH -> IDLE.
- IDLE:
  - `start`=1 is accepted and latches `len_r` = min(len, DEPTH).
  - If `len_r` = 0, go directly to FINISH.
  - `start` while not IDLE is ignored.
  - `start` and `prog_we` in the same IDLE cycle: the write completes and the run starts; the written entry is visible to the run.
- CLEAR: `mo_rst`=1 for exactly 1 cycle with `mo_operand`=000; `pc`=0; hold counter cleared.
- ISSUE:
  - `mo_*` are driven from mem[pc] (read combinationally or pre-fetched; either way valid in the first ISSUE cycle of each pc).
  - The hold counter counts 0..HOLD-1. At HOLD-1, `pc` increments.
  - When `pc` = `len_r`-1 and the count reaches HOLD-1, go to DRAIN.
  - Operand 000 is issued normally and occupies HOLD cycles.
- DRAIN: 1 cycle with `mo_operand`=000, letting the final write-back settle.
- FINISH:
  - `result` <= `mo_out`; `done`=1 for this cycle only; `busy` stays 1 this cycle.
  - Next cycle returns to IDLE with `busy`=0.
- Outside ISSUE: `mo_operand`=000, `mo_index*`=0, `mo_value`=0.
- Timing: with start accepted at edge t, `done` is high in cycle t+2+len_r*HOLD+1 (CLEAR, ISSUE cycles, DRAIN, then FINISH).
- Width rule: operand, index and value fields are passed through unmodified; no arithmetic is performed on them.

Test Plan:
- Load 3 instructions (Q16), len=3, HOLD=2: {001, i1=1, value 0x00020000}, {010, i2=2, value 0x00030000}, {011, i1=1, i2=2, i3=1}; pulse start.
  - Required: `mo_rst` high 1 cycle, then operands 001,001,010,010,011,011, then 000.
  - `done` exactly 9 cycles after the start edge.
  - `result` = `mo_out` from the machine model, expected 0x00050000.
- len=0, start -> `busy` for 2 cycles, `done` pulse, no `mo_operand` other than 000.
- len=20 with DEPTH=16 -> exactly 16 instructions issued (32 ISSUE cycles); `pc` stops at 15.
- `prog_we` and `start` pulsed while busy -> memory unchanged (read back by a rerun), run timing unaltered, no second done.
- Assert `rst` in the 3rd ISSUE cycle -> next cycle all outputs at reset values, no done; a restart then reruns the program from pc=0 with the memory contents retained.
- Back-to-back: `start` in the IDLE cycle right after done -> accepted; `result` holds the old value until the new done.
